// File: rtl/elev_pkg.sv
// Shared elevator definitions: E_FSM call codes, directions and serialiser states.
package elev_pkg;

   localparam int NUM_BTN = 6;

   localparam logic [2:0] _NONE = 3'b000;
   localparam logic [2:0] _1U   = 3'b001;
   localparam logic [2:0] _2U   = 3'b010;
   localparam logic [2:0] _3U   = 3'b011;
   localparam logic [2:0] _2D   = 3'b110;
   localparam logic [2:0] _3D   = 3'b111;
   localparam logic [2:0] _4D   = 3'b100;

   localparam logic [1:0] STAY = 2'b00;
   localparam logic [1:0] UP   = 2'b01;
   localparam logic [1:0] DOWN = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_GAP  = 2'd2
   } ser_state_e;

   // Button index (bit position in btn/pending) to the code E_FSM expects.
   function automatic logic [2:0] idx_to_code(input logic [2:0] idx);
      logic [2:0] code;
      case (idx)
         3'd0:    code = _1U;
         3'd1:    code = _2U;
         3'd2:    code = _3U;
         3'd3:    code = _2D;
         3'd4:    code = _3D;
         3'd5:    code = _4D;
         default: code = _NONE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/hall_call_encoder_if.sv
// Button/lamp and call-code bundle between the hall panel side and E_FSM side.
interface hall_call_encoder_if;
   import elev_pkg::*;

   logic [NUM_BTN-1:0] btn;
   logic               enable;
   logic [2:0]         din_out;
   logic               din_valid;
   logic [NUM_BTN-1:0] pending;

   modport master (output btn, enable, input din_out, din_valid, pending);
   modport slave  (input btn, enable, output din_out, din_valid, pending);

endinterface

// File: rtl/hall_call_encoder_btn_debounce.sv
// One-bit debouncer; press_o pulses on the edge the debounced level rises.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic level_o,
   output logic press_o
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          flip;

   // The flip edge also clears the count, so it never exceeds DEBOUNCE_CYCLES-1.
   always_comb begin
      flip    = (raw_i != level_q) && (cnt_q == LAST);
      cnt_d   = '0;
      level_d = level_q;
      if (flip) begin
         level_d = raw_i;
      end else if (raw_i != level_q) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level_o = level_q;
   assign press_o = flip & raw_i;

endmodule

// File: rtl/hall_call_encoder.sv
// Debounces hall buttons, latches pending calls and serialises them round-robin onto din_out.
module hall_call_encoder
   import elev_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 3,
   parameter int HOLD_CYCLES     = 5,
   parameter int GAP_CYCLES      = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   hall_call_encoder_if.slave  bus
);
   localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

   logic [NUM_BTN-1:0] press_vec, level_vec;
   logic               unused_levels;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BTN; gi++) begin : g_db
         btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw_i   (bus.btn[gi]),
            .level_o (level_vec[gi]),
            .press_o (press_vec[gi])
         );
      end
   endgenerate

   assign unused_levels = ^level_vec;

   ser_state_e         state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2:0]         rr_ptr_q, cur_idx_q;
   logic [2:0]         din_out_q;
   logic               din_valid_q;
   logic [NUM_BTN-1:0] pending_q, pending_d;

   logic               found;
   logic [2:0]         sel_idx;
   logic               issue;
   logic [NUM_BTN-1:0] absorb_mask;

   // First pending bit at or above rr_ptr, wrapping modulo NUM_BTN.
   always_comb begin
      int j;
      found   = 1'b0;
      sel_idx = 3'd0;
      j       = 0;
      for (int k = 0; k < NUM_BTN; k++) begin
         j = int'(rr_ptr_q) + k;
         if (j >= NUM_BTN) j = j - NUM_BTN;
         if (!found && pending_q[j]) begin
            found   = 1'b1;
            sel_idx = 3'(j);
         end
      end
   end

   assign issue = (state_q == ST_IDLE) && bus.enable && found;

   always_comb begin
      absorb_mask = '0;
      if (state_q == ST_HOLD) absorb_mask[cur_idx_q] = 1'b1;
      pending_d = pending_q | (press_vec & ~absorb_mask);
      if (issue) pending_d[sel_idx] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rr_ptr_q    <= 3'd0;
         cur_idx_q   <= 3'd0;
         din_out_q   <= _NONE;
         din_valid_q <= 1'b0;
         pending_q   <= '0;
      end else begin
         pending_q <= pending_d;
         case (state_q)
            ST_IDLE: begin
               if (issue) begin
                  din_out_q   <= idx_to_code(sel_idx);
                  din_valid_q <= 1'b1;
                  cur_idx_q   <= sel_idx;
                  rr_ptr_q    <= (sel_idx == 3'd5) ? 3'd0 : sel_idx + 3'd1;
                  cnt_q       <= '0;
                  state_q     <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  din_out_q   <= _NONE;
                  din_valid_q <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= ST_GAP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.din_out   = din_out_q;
   assign bus.din_valid = din_valid_q;
   assign bus.pending   = pending_q;

endmodule

// File: tb/tb_hall_call_encoder.sv
// Cycle-by-cycle vector table for hall_call_encoder plus a hand-written latency/hold check.
module tb_hall_call_encoder;

   typedef struct {
      logic       rst_n;
      logic [5:0] btn;
      logic       en;
      logic [2:0] din;
      logic       vld;
      logic [5:0] pend;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   vec_t vecs[$];

   hall_call_encoder_if bus();

   hall_call_encoder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic add(input logic r, input logic [5:0] b, input logic e,
                      input logic [2:0] d, input logic v, input logic [5:0] p, input int reps);
      vec_t t;
      t.rst_n = r; t.btn = b; t.en = e; t.din = d; t.vld = v; t.pend = p;
      for (int i = 0; i < reps; i++) vecs.push_back(t);
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   initial begin
      int n;
      int h;
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.btn = 6'h3F;
      bus.enable = 1'b1;

      // reset with all buttons high, then single 3U press held
      add(0, 6'h3F, 1, 3'b000, 0, 6'h00, 2);
      add(1, 6'h04, 1, 3'b000, 0, 6'h00, 2);
      add(1, 6'h04, 1, 3'b000, 0, 6'h04, 1);
      add(1, 6'h04, 1, 3'b011, 1, 6'h00, 5);
      add(1, 6'h04, 1, 3'b000, 0, 6'h00, 2);
      add(1, 6'h00, 1, 3'b000, 0, 6'h00, 4);
      // glitch shorter than the debounce window
      add(1, 6'h01, 1, 3'b000, 0, 6'h00, 2);
      add(1, 6'h00, 1, 3'b000, 0, 6'h00, 20);
      // round-robin from rr_ptr=0: 2U then 4D
      add(0, 6'h00, 1, 3'b000, 0, 6'h00, 1);
      add(1, 6'h22, 1, 3'b000, 0, 6'h00, 2);
      add(1, 6'h22, 1, 3'b000, 0, 6'h22, 1);
      add(1, 6'h22, 1, 3'b010, 1, 6'h20, 5);
      add(1, 6'h22, 1, 3'b000, 0, 6'h20, 2);
      add(1, 6'h22, 1, 3'b100, 1, 6'h00, 5);
      add(1, 6'h00, 1, 3'b000, 0, 6'h00, 4);
      // single 2U moves rr_ptr to 2
      add(1, 6'h02, 1, 3'b000, 0, 6'h00, 2);
      add(1, 6'h02, 1, 3'b000, 0, 6'h02, 1);
      add(1, 6'h02, 1, 3'b010, 1, 6'h00, 5);
      add(1, 6'h00, 1, 3'b000, 0, 6'h00, 4);
      // 2U+2D from rr_ptr=2: 2D first
      add(1, 6'h0A, 1, 3'b000, 0, 6'h00, 2);
      add(1, 6'h0A, 1, 3'b000, 0, 6'h0A, 1);
      add(1, 6'h0A, 1, 3'b110, 1, 6'h02, 5);
      add(1, 6'h0A, 1, 3'b000, 0, 6'h02, 2);
      add(1, 6'h0A, 1, 3'b010, 1, 6'h00, 5);
      add(1, 6'h00, 1, 3'b000, 0, 6'h00, 4);
      // 3D re-pressed so the press lands on the last HOLD edge: absorbed
      add(1, 6'h10, 1, 3'b000, 0, 6'h00, 2);
      add(1, 6'h10, 1, 3'b000, 0, 6'h10, 1);
      add(1, 6'h00, 1, 3'b111, 1, 6'h00, 3);
      add(1, 6'h10, 1, 3'b111, 1, 6'h00, 2);
      add(1, 6'h10, 1, 3'b000, 0, 6'h00, 4);
      add(1, 6'h00, 1, 3'b000, 0, 6'h00, 3);
      // fresh 3D press is issued again
      add(1, 6'h10, 1, 3'b000, 0, 6'h00, 2);
      add(1, 6'h10, 1, 3'b000, 0, 6'h10, 1);
      add(1, 6'h10, 1, 3'b111, 1, 6'h00, 5);
      add(1, 6'h00, 1, 3'b000, 0, 6'h00, 4);
      // enable low holds the pending 1U until enable rises
      add(1, 6'h01, 0, 3'b000, 0, 6'h00, 2);
      add(1, 6'h01, 0, 3'b000, 0, 6'h01, 6);
      add(1, 6'h01, 1, 3'b001, 1, 6'h00, 5);
      add(1, 6'h00, 1, 3'b000, 0, 6'h00, 4);
      // reset on the 3rd HOLD cycle of 3U with 3D pending
      add(1, 6'h14, 1, 3'b000, 0, 6'h00, 2);
      add(1, 6'h14, 1, 3'b000, 0, 6'h14, 1);
      add(1, 6'h14, 1, 3'b011, 1, 6'h10, 3);
      add(0, 6'h14, 1, 3'b000, 0, 6'h00, 1);
      add(1, 6'h00, 1, 3'b000, 0, 6'h00, 10);

      foreach (vecs[i]) begin
         rst_n      = vecs[i].rst_n;
         bus.btn    = vecs[i].btn;
         bus.enable = vecs[i].en;
         @(negedge clk);
         check($sformatf("v%0d.din", i), 8'(bus.din_out), 8'(vecs[i].din));
         check($sformatf("v%0d.valid", i), 8'(bus.din_valid), 8'(vecs[i].vld));
         check($sformatf("v%0d.pending", i), 8'(bus.pending), 8'(vecs[i].pend));
      end

      // 4D after reset: latency DEBOUNCE_CYCLES+1 edges, held HOLD_CYCLES samples
      bus.btn = 6'h20;
      n = 0;
      while (n < 20 && bus.din_valid !== 1'b1) begin
         @(negedge clk);
         n++;
      end
      check("hs.latency", 8'(n), 8'd4);
      check("hs.valid", 8'(bus.din_valid), 8'd1);
      check("hs.code", 8'(bus.din_out), 8'h4);
      h = 0;
      while (h < 20 && bus.din_valid === 1'b1) begin
         @(negedge clk);
         h++;
      end
      check("hs.hold_len", 8'(h), 8'd5);
      check("hs.gap_din", 8'(bus.din_out), 8'h0);
      check("hs.pending", 8'(bus.pending), 8'h00);
      bus.btn = 6'h00;
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hall_call_encoder.md
Name: hall_call_encoder

Overview:
Upstream stage of E_FSM; its din_out drives the E_FSM din input. Debounces the six hall-call buttons and latches each press as a pending call. Serialises pending calls into the 3-bit call codes E_FSM consumes. Each code is held for a fixed number of cycles and followed by a _NONE gap. Also drives the hall lamps.

Parameters:
DEBOUNCE_CYCLES, 3, consecutive identical samples required to accept a button level change (>=1)
HOLD_CYCLES, 5, cycles each call code is held on din_out (>=1)
GAP_CYCLES, 1, cycles of _NONE (3'b000) driven after each hold (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
btn  input  6  raw hall buttons: [0]=1U [1]=2U [2]=3U [3]=2D [4]=3D [5]=4D
enable  input  1  when 0, no new call is issued; presses are still latched
din_out  output  3  call code to E_FSM din; 3'b000 (_NONE) when idle or in gap
din_valid  output  1  1 while din_out carries a call code (HOLD state)
pending  output  6  registered hall-lamp vector; bit set = call latched, not yet issued

Behaviour:
- Reset: one clock, synchronous, active-low, sampled on the rising edge of clk.
  - Reset values: din_out=000, din_valid=0, pending=000000, state=IDLE, rr_ptr=0.
  - All debounce counters clear; debounced levels = 0.
- Reset asserted mid-HOLD or mid-GAP: all of the above apply on that edge; the call in flight is dropped, not re-queued.
- Debounce, per bit:
  - Counter of width clog2(DEBOUNCE_CYCLES+1), saturating.
  - Raw sample differs from the debounced level: counter increments. Raw sample equals it: counter clears.
  - The debounced level flips on the edge where the count reaches DEBOUNCE_CYCLES.
  - A 0->1 flip is a press. Pulses shorter than DEBOUNCE_CYCLES samples are ignored.
  - A held button yields exactly one press; it must debounce low before it can press again.
- Pending latch:
  - A press sets pending[i] on the same edge the debounced level flips.
  - A press on an already-pending bit has no effect.
  - A press for the index currently in HOLD is absorbed and not re-queued.
- Serialiser FSM, states IDLE, HOLD, GAP:
  - IDLE, with enable=1 and pending!=0:
    - Select the first set bit searching from rr_ptr upward, mod 6.
    - Next edge: din_out=code(i), din_valid=1, pending[i] cleared, rr_ptr=(i+1) mod 6, state goes to HOLD.
  - HOLD: lasts exactly HOLD_CYCLES edges with the code stable. Then din_out=000, din_valid=0, state goes to GAP.
  - GAP: lasts exactly GAP_CYCLES edges, then state goes to IDLE.
  - Back-to-back calls are therefore separated by GAP_CYCLES+1 cycles of 000, including the IDLE decision cycle.
  - enable=0 is checked only in IDLE; a HOLD or GAP already in progress always completes.
- Code map: idx0=3'b001, 1=010, 2=011, 3=110, 4=111, 5=100.
- Press-to-output latency: first high sample at edge k gives pending set at edge k+DEBOUNCE_CYCLES-1. din_out shows the code at edge k+DEBOUNCE_CYCLES, provided the serialiser is IDLE and enabled.
- A press landing in the same cycle that IDLE selects: it is seen in the next IDLE evaluation.
- All outputs are registered; there is no combinational path from btn or enable to any output.

Decomposition:
- Shared package elev_pkg:
  - Call-code constants _1U, _2U, _3U, _2D, _3D, _4D, _NONE.
  - Direction constants UP, DOWN, STAY.
  - Function idx_to_code(3-bit idx) -> 3-bit code.
  - Serialiser state encoding.
- Sub-module btn_debounce: one bit, parameter DEBOUNCE_CYCLES, outputs level and press pulse. Instantiated 6x.

Test Plan:
- Reset: rst_n=0 for 2 cycles with btn=6'h3F -> din_out=000, din_valid=0, pending=0. After release, presses debounce normally.
- Single press: btn[2] high from edge 1 -> pending[2]=1 at edge 3. din_out=011 with valid=1 on edges 4..8. pending[2] clears at edge 4. din_out=000 at edge 9, then IDLE.
- Glitch: btn[0] high for 2 samples, then low -> pending stays 0, din_out stays 000 for 20 cycles.
- Round-robin: btn[1] and btn[5] pressed together after reset -> 010 held 5 cycles, then 2 cycles of 000, then 100 held 5 cycles. Repeating after rr_ptr=2 with btn[1]+btn[3] -> 110 then 010.
- Absorb and re-issue, plus enable: 3D re-pressed during its own HOLD -> no second 111. Release, then press again -> 111 issued again. With enable=0 and pending=000001 -> din_out held at 000. Raising enable -> 001 appears 1 edge later.
- Reset mid-HOLD: rst_n=0 on the 3rd HOLD cycle of 011 with pending[4]=1 -> next edge din_out=000, pending=0. After release, nothing is issued.
